// File: rtl/early_result_queue_pkg.sv
// Shared widths and the buffered-entry layout for the early result queue.
package early_result_queue_pkg;
  localparam int DATA_MSB = 31;
  localparam int TAG_MSB  = 3;
  localparam int Q_DEPTH  = 4;

  typedef struct packed {
    logic [DATA_MSB:0] data;
    logic [TAG_MSB:0]  tag;
  } early_entry_t;
endpackage

// File: rtl/early_result_queue.sv
// Small FIFO of rename-stage results (LUI/AUIPC, JAL/JALR link) waiting for the CDB.
module early_result_queue
  import early_result_queue_pkg::*;
#(
  parameter int WIDTH = DATA_MSB,
  parameter int ROB   = TAG_MSB,
  parameter int DEPTH = Q_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     earlyWrite,
  input  logic                     isJAL,
  input  logic [WIDTH:0]           earlyResult,
  input  logic [WIDTH:0]           seqPC,
  input  logic [ROB:0]             robTag,
  input  logic                     flush,
  input  logic                     cdbGrant,
  output logic                     cdbRequest,
  output logic [WIDTH:0]           cdbResult,
  output logic [ROB:0]             cdbTag,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WIDTH:0] data;
    logic [ROB:0]   tag;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            enq, deq;

  // All flags come from registered state only; no path from earlyWrite to the request.
  always_comb begin
    cdbRequest = (cnt_q != '0);
    full       = (cnt_q == CW'(DEPTH));
    count      = cnt_q;
    enq        = earlyWrite & ~full;
    deq        = cdbRequest & cdbGrant;
    cnt_d      = cnt_q + CW'(enq) - CW'(deq);
    cdbResult  = '0;
    cdbTag     = '0;
    if (cdbRequest) begin
      cdbResult = mem_q[head_q].data;
      cdbTag    = mem_q[head_q].tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN || flush) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq) begin
        mem_q[tail_q] <= '{data: (isJAL ? seqPC : earlyResult), tag: robTag};
        tail_q        <= tail_q + 1'b1;
      end
      if (deq) head_q <= head_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_early_result_queue.sv
// Directed plus randomized checks of early_result_queue against a queue-based model.
module tb_early_result_queue;
  logic        clk = 0;
  logic        resetN, earlyWrite, isJAL, flush, cdbGrant;
  logic [31:0] earlyResult, seqPC;
  logic [3:0]  robTag;
  logic        cdbRequest, full;
  logic [31:0] cdbResult;
  logic [3:0]  cdbTag;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [31:0] data; logic [3:0] tag; } ent_t;
  ent_t model[$];
  logic [3:0] granted[$];

  early_result_queue dut (
    .clk(clk), .resetN(resetN), .earlyWrite(earlyWrite), .isJAL(isJAL),
    .earlyResult(earlyResult), .seqPC(seqPC), .robTag(robTag), .flush(flush),
    .cdbGrant(cdbGrant), .cdbRequest(cdbRequest), .cdbResult(cdbResult),
    .cdbTag(cdbTag), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic chk_model(input string name);
    int n = model.size();
    chk({name, ".req"},   64'(cdbRequest), 64'(n != 0));
    chk({name, ".count"}, 64'(count),      64'(n));
    chk({name, ".full"},  64'(full),       64'(n == 4));
    chk({name, ".data"},  64'(cdbResult),  (n != 0) ? 64'(model[0].data) : 64'd0);
    chk({name, ".tag"},   64'(cdbTag),     (n != 0) ? 64'(model[0].tag)  : 64'd0);
  endtask

  // One clock: drive inputs, advance the model per the queue rules, check after the edge.
  task automatic cyc(input logic ew, input logic jal, input logic [31:0] er,
                     input logic [31:0] pc, input logic [3:0] tg,
                     input logic fl, input logic gr, input logic rn, input string name);
    bit do_enq, do_deq;
    ent_t e;
    resetN = rn; earlyWrite = ew; isJAL = jal; earlyResult = er; seqPC = pc;
    robTag = tg; flush = fl; cdbGrant = gr;
    #1;
    if (rn && !fl && gr && cdbRequest) granted.push_back(cdbTag);
    do_enq = ew && (model.size() < 4);
    do_deq = gr && (model.size() != 0);
    @(posedge clk); #1;
    if (!rn || fl) model.delete();
    else begin
      if (do_deq) void'(model.pop_front());
      if (do_enq) begin e.data = jal ? pc : er; e.tag = tg; model.push_back(e); end
    end
    chk_model(name);
  endtask

  task automatic idle(input logic gr, input string name);
    cyc(0, 0, 32'h0, 32'h0, 4'h0, 0, gr, 1, name);
  endtask

  task automatic put(input logic [3:0] tg, input logic gr, input string name);
    cyc(1, 0, 32'hA000_0000 | 32'(tg), 32'hDEAD_0000, tg, 0, gr, 1, name);
  endtask

  initial begin
    logic [3:0] exp_order [6];
    exp_order = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};

    // Reset then idle
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "rst0");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "rst1");
    chk("rst.count", 64'(count), 64'd0);
    idle(0, "idle");
    chk("idle.req", 64'(cdbRequest), 64'd0);

    // Single LUI, held without grant, then granted
    cyc(1, 0, 32'h12345000, 32'h0, 4'd5, 0, 0, 1, "lui");
    chk("lui.data", 64'(cdbResult), 64'h12345000);
    chk("lui.tag",  64'(cdbTag),    64'd5);
    repeat (3) idle(0, "lui.hold");
    chk("lui.hold.data", 64'(cdbResult), 64'h12345000);
    idle(1, "lui.grant");
    chk("lui.grant.req", 64'(cdbRequest), 64'd0);

    // JAL link value selects seqPC
    cyc(1, 1, 32'h80, 32'h41, 4'd2, 0, 0, 1, "jal");
    chk("jal.data", 64'(cdbResult), 64'h41);
    chk("jal.tag",  64'(cdbTag),    64'd2);
    idle(1, "jal.drain");

    // Fill, overflow with grant, wrap
    granted.delete();
    for (int t = 1; t <= 4; t++) put(4'(t), 0, "fill");
    chk("fill.full", 64'(full), 64'd1);
    put(4'd6, 1, "ovf");
    chk("ovf.count", 64'(count), 64'd3);
    put(4'd7, 1, "wrap7");
    idle(1, "wrap.d3");
    put(4'd8, 1, "wrap8");
    idle(1, "wrap.d7");
    idle(1, "wrap.d8");
    chk("wrap.n", 64'(granted.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk("wrap.order", (i < granted.size()) ? 64'(granted[i]) : 64'hF0, 64'(exp_order[i]));

    // Simultaneous enqueue + grant at count 2
    put(4'd10, 0, "s.a");
    put(4'd11, 0, "s.b");
    put(4'd12, 1, "s.both");
    chk("s.count", 64'(count), 64'd2);
    chk("s.head",  64'(cdbTag), 64'd11);
    idle(1, "s.d1");
    idle(1, "s.d2");

    // Empty + enqueue + grant: grant ignored
    put(4'd13, 1, "eg");
    chk("eg.count", 64'(count), 64'd1);
    idle(1, "eg.d");

    // Flush mid-operation
    for (int t = 1; t <= 3; t++) put(4'(t), 0, "fl.fill");
    cyc(1, 0, 32'h5555, 32'h0, 4'd14, 1, 1, 1, "flush");
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.req",   64'(cdbRequest), 64'd0);
    put(4'd9, 0, "post");
    chk("post.tag", 64'(cdbTag), 64'd9);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic ew, rn, fl;
      ew = ($urandom_range(0, 2) != 0) && (model.size() < 4);
      rn = ($urandom_range(0, 49) != 0);
      fl = ($urandom_range(0, 19) == 0);
      cyc(ew, 1'($urandom), $urandom, $urandom, 4'($urandom), fl,
          1'($urandom), rn, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
